// File: rtl/mux2_64bit_arbiter.sv
// Round-robin arbiter for two valid/ready requesters sharing one 64-bit 2:1 mux,
// with a one-entry registered output stage and saturating per-requester grant counters.
module mux2_64bit_arbiter #(
    parameter int unsigned W     = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [W-1:0]     req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [W-1:0]     req1_data,
    output logic             req1_ready,
    output logic             sel,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state_q;
    state_t state_d;
    logic   last_grant;
    logic   choice;
    logic   load_en;
    logic   any_valid;
    logic   xfer;

    assign any_valid = req0_valid | req1_valid;
    assign load_en   = (state_q == EMPTY) | out_ready;
    assign xfer      = load_en & any_valid;
    assign out_valid = (state_q == FULL);

    // Round-robin pick; with no requester the select parks on the last grant.
    always_comb begin
        choice = last_grant;
        if (req0_valid && req1_valid) begin
            choice = ~last_grant;
        end else if (req0_valid) begin
            choice = 1'b0;
        end else if (req1_valid) begin
            choice = 1'b1;
        end
    end

    // Next-state and handshake outputs; readies are held low while in reset.
    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        sel        = choice;
        if (load_en) begin
            state_d    = any_valid ? FULL : EMPTY;
            req0_ready = rst_n & req0_valid & ~choice;
            req1_ready = rst_n & req1_valid & choice;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output word, source tag, priority pointer and debug counters move only on a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_src    <= 1'b0;
            last_grant <= 1'b1;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (xfer) begin
            out_data   <= choice ? req1_data : req0_data;
            out_src    <= choice;
            last_grant <= choice;
            if (!choice && grant_cnt0 != CNT_MAX) begin
                grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            end
            if (choice && grant_cnt1 != CNT_MAX) begin
                grant_cnt1 <= grant_cnt1 + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux2_64bit_arbiter.sv
// Scoreboard bench for mux2_64bit_arbiter: directed scenarios plus protocol-legal
// random traffic, checked against a round-robin reference model.
module tb_mux2_64bit_arbiter;

    localparam int unsigned W     = 64;
    localparam int unsigned CNT_W = 3;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid;
    logic [W-1:0]     req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [W-1:0]     req1_data;
    logic             req1_ready;
    logic             sel;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic             out_src;
    logic             out_ready;
    logic [CNT_W-1:0] grant_cnt0;
    logic [CNT_W-1:0] grant_cnt1;

    mux2_64bit_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .sel        (sel),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_ready  (out_ready),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         src;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model state: round-robin pointer, output occupancy, transfer counts.
    bit m_last = 1'b1;
    bit m_full = 1'b0;
    int m_cnt0 = 0;
    int m_cnt1 = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: whatever the DUT presents must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() == 0) begin
                chk("out_valid_empty", 64'(out_valid), 64'(0));
            end else begin
                chk("out_valid_full", 64'(out_valid), 64'(1));
                chk("out_data", out_data, sb[0].data);
                chk("out_src", 64'(out_src), 64'(sb[0].src));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    // Predictor: decide this cycle's grant from the round-robin rule and queue the result.
    always @(negedge clk) begin
        bit load;
        bit pick;
        #1;
        if (!rst_n) begin
            m_last = 1'b1;
            m_full = 1'b0;
            m_cnt0 = 0;
            m_cnt1 = 0;
            sb.delete();
        end else begin
            chk("grant_cnt0", 64'(grant_cnt0), 64'(m_cnt0));
            chk("grant_cnt1", 64'(grant_cnt1), 64'(m_cnt1));
            load = !m_full || out_ready;
            if (req0_valid && req1_valid) pick = !m_last;
            else if (req0_valid)          pick = 1'b0;
            else if (req1_valid)          pick = 1'b1;
            else                          pick = m_last;
            chk("sel", 64'(sel), 64'(pick));
            chk("req0_ready", 64'(req0_ready), 64'(load && req0_valid && !pick));
            chk("req1_ready", 64'(req1_ready), 64'(load && req1_valid && pick));
            if (load) begin
                if (req0_valid || req1_valid) begin
                    sb.push_back('{pick ? req1_data : req0_data, pick});
                    m_last = pick;
                    m_full = 1'b1;
                    if (!pick && m_cnt0 < CMAX) m_cnt0++;
                    if (pick && m_cnt1 < CMAX)  m_cnt1++;
                end else begin
                    m_full = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v0, input logic [W-1:0] d0,
                          input logic v1, input logic [W-1:0] d1, input logic ordy);
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
        out_ready  = ordy;
    endtask

    // Asynchronous reset pulse between edges, with immediate checks while asserted.
    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", out_data, 64'(0));
        chk("rst_out_src", 64'(out_src), 64'(0));
        chk("rst_req0_ready", 64'(req0_ready), 64'(0));
        chk("rst_req1_ready", 64'(req1_ready), 64'(0));
        chk("rst_cnt0", 64'(grant_cnt0), 64'(0));
        chk("rst_cnt1", 64'(grant_cnt1), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Random traffic that obeys the hold-until-ready rule for both requesters.
    task automatic run_random(input int cycles, input int pv, input int pr);
        logic a0;
        logic a1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            a0 = req0_ready;
            a1 = req1_ready;
            @(posedge clk);
            #1;
            if (!req0_valid || a0) begin
                req0_valid = ($urandom_range(99) < pv);
                req0_data  = {$urandom, $urandom};
            end
            if (!req1_valid || a1) begin
                req1_valid = ($urandom_range(99) < pv);
                req1_data  = {$urandom, $urandom};
            end
            out_ready = ($urandom_range(99) < pr);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1'b1, 64'h1234, 1'b1, 64'h5678, 1'b1);
        #3;
        chk("rst_out_valid_t0", 64'(out_valid), 64'(0));
        chk("rst_ready0_t0", 64'(req0_ready), 64'(0));
        chk("rst_ready1_t0", 64'(req1_ready), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("first_sel", 64'(sel), 64'(0));
        chk("first_req0_ready", 64'(req0_ready), 64'(1));
        chk("first_req1_ready", 64'(req1_ready), 64'(0));
        tick();

        // Single requesters
        set_in(1'b1, 64'h0000_0000_0000_0001, 1'b0, '0, 1'b1);
        tick();
        set_in(1'b0, '0, 1'b1, 64'h8000_0000_0000_0000, 1'b1);
        tick();
        set_in(1'b0, '0, 1'b0, '0, 1'b1);
        tick();
        pulse_reset();

        // Contention: alternating grants
        set_in(1'b1, {4{16'hAAAA}}, 1'b1, {4{16'h5555}}, 1'b1);
        repeat (6) tick();
        set_in(1'b0, '0, 1'b0, '0, 1'b1);
        tick();

        // Backpressure with both requests pending, then release without a bubble
        set_in(1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, '0, 1'b0);
        tick();
        set_in(1'b1, 64'hDEAD_BEEF_0000_0002, 1'b1, 64'hCAFE_F00D_0000_0003, 1'b0);
        repeat (4) tick();
        out_ready = 1'b1;
        tick();
        set_in(1'b0, '0, 1'b0, '0, 1'b1);
        repeat (2) tick();

        // Idle cycles must not rotate priority
        set_in(1'b1, 64'h0F0F, 1'b0, '0, 1'b1);
        tick();
        set_in(1'b0, '0, 1'b0, '0, 1'b1);
        repeat (3) tick();
        set_in(1'b1, 64'h1111, 1'b1, 64'h2222, 1'b1);
        #1;
        chk("idle_no_rotate_sel", 64'(sel), 64'(1));
        tick();
        set_in(1'b0, '0, 1'b0, '0, 1'b1);
        tick();
        pulse_reset();

        // Counter saturation, then reset while the output holds a word
        set_in(1'b1, 64'h77, 1'b0, '0, 1'b1);
        repeat (CMAX + 3) tick();
        chk("sat_cnt0", 64'(grant_cnt0), 64'(CMAX));
        out_ready = 1'b0;
        tick();
        chk("full_before_reset", 64'(out_valid), 64'(1));
        set_in(1'b0, '0, 1'b0, '0, 1'b0);
        pulse_reset();
        set_in(1'b0, '0, 1'b0, '0, 1'b1);
        tick();

        for (int k = 0; k < 4; k++) begin
            run_random(400, 30 + 20 * k, 40 + 15 * k);
            set_in(1'b0, '0, 1'b0, '0, 1'b1);
            repeat (2) tick();
            pulse_reset();
        end

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux2_64bit_arbiter.md
Name: mux2_64bit_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 64-bit 2:1 datapath mux between two valid/ready requesters. It drives the mux select and captures the selected word into a one-entry registered output stage with its own valid/ready handshake. It also keeps saturating per-requester grant counters for debug. It sits in front of the 64-bit mux and replaces ad-hoc static select wiring.

Parameters:
W, 64, data width of each requester and of the output.
CNT_W, 16, width of each grant counter.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req0_valid  input  1  requester 0 has a word.
req0_data  input  W  requester 0 word; the mux low half (select 0).
req0_ready  output  1  requester 0 word accepted this cycle.
req1_valid  input  1  requester 1 has a word.
req1_data  input  W  requester 1 word; the mux high half (select 1).
req1_ready  output  1  requester 1 word accepted this cycle.
sel  output  1  mux select for the current cycle (0 = req0, 1 = req1).
out_valid  output  1  output register holds a word.
out_data  output  W  registered selected word.
out_src  output  1  requester index that supplied out_data.
out_ready  input  1  consumer accepts out_data.
grant_cnt0  output  CNT_W  accepted-transfer count for requester 0.
grant_cnt1  output  CNT_W  accepted-transfer count for requester 1.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low. Names are clk and rst_n.
- Reset values: out_valid=0, out_data=0, out_src=0, last_grant=1 (so req0 wins the first contention), grant_cnt0=0, grant_cnt1=0. req0_ready and req1_ready are forced to 0 while rst_n=0.
- State is out_valid. EMPTY (0) means the register is free. FULL (1) means it holds a word awaiting out_ready.
- load_en = !out_valid || out_ready. This gives full throughput: a word can be replaced in the same cycle it is consumed.
- Choice (combinational):
  - Only req0_valid → choose 0.
  - Only req1_valid → choose 1.
  - Both valid → choose !last_grant.
  - Neither valid → sel holds last_grant.
- sel = choice, even when load_en=0. The mux is always driven.
- reqX_ready = load_en && reqX_valid && (choice == X). At most one ready is high per cycle. A ready is never high without its valid.
- On a clock edge with load_en=1 and a transfer (some valid):
  - out_data <= selected data, out_src <= choice, out_valid <= 1, last_grant <= choice.
  - grant_cntX increments and saturates at 2^CNT_W-1.
- On a clock edge with load_en=1 and no valid: out_valid <= 0. out_data and out_src hold their values.
- On a clock edge with load_en=0: all registers hold. out_data must be stable while out_valid=1 and out_ready=0.
- Latency: a word accepted in cycle N appears on out_data with out_valid=1 in cycle N+1.
- Requesters must hold valid and data until ready. The arbiter does not drop or reorder a requester's words.
- Fairness: with both requesters continuously valid and out_ready=1, grants alternate 0,1,0,1… A requester waits at most one transfer.
- last_grant changes only on a transfer. Idle cycles do not rotate priority.
- Reset mid-operation: a held output word is discarded (out_valid=0 immediately, asynchronously). The counters clear. The next contention goes to req0.

Test Plan:
- Reset: assert rst_n=0 with both valids high → out_valid=0, out_data=0, both readies 0, counters 0. Release → first cycle req0_ready=1, sel=0.
- Single requester: req0_data=64'h0000_0000_0000_0001, only req0_valid, out_ready=1 → next cycle out_data=64'h1, out_src=0, grant_cnt0=1. Repeat with req1_data=64'h8000_0000_0000_0000 → out_src=1, sel=1.
- Contention: both valid continuously, req0_data=64'hAAAA…, req1_data=64'h5555…, out_ready=1 for 6 cycles → out_src sequence 0,1,0,1,0,1. grant_cnt0=3, grant_cnt1=3.
- Backpressure: hold out_ready=0 after one transfer → out_data stable, both readies 0 for 4 cycles. Raise out_ready → the pending request transfers the same cycle, with no bubble.
- Idle between bursts: grant req0, idle 3 cycles, then both valid → req1 wins, because last_grant was not rotated by the idle cycles.
- Saturation/reset: with CNT_W=2, make 5 req0 transfers → grant_cnt0=3. Pulse rst_n low mid-FULL → out_valid=0 immediately, counters 0.
